// File: rtl/single_cycle_defs.sv
// Shared definitions for the single-cycle core: load/store unit states and
// the memory access size codes carried in funct3.
package single_cycle_defs;

  typedef enum logic [2:0] {
    LSU_IDLE    = 3'd0,
    LSU_WR_REQ  = 3'd1,
    LSU_WR_RESP = 3'd2,
    LSU_RD_REQ  = 3'd3,
    LSU_RD_RESP = 3'd4,
    LSU_DONE    = 3'd5
  } lsu_state_e;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Unknown size codes are treated as misaligned so they never reach the bus.
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      MEM_B, MEM_BU: mis = 1'b0;
      MEM_H, MEM_HU: mis = lo[0];
      MEM_W:         mis = (lo != 2'b00);
      default:       mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobe and lane
// replication, load lane extraction with sign/zero extension.
module lsu_align
  import single_cycle_defs::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_fmt,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign misalign = access_misaligned(st_funct3, st_addr_lo);

  // Store strobe and data replicated across every lane the size can occupy.
  always_comb begin
    wstrb = 4'h0;
    wdata = 32'h0000_0000;
    case (st_funct3)
      MEM_B, MEM_BU: begin
        wstrb = 4'b0001 << st_addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        wstrb = 4'b0011 << st_addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      MEM_W: begin
        wstrb = 4'hF;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'h0;
        wdata = 32'h0000_0000;
      end
    endcase
  end

  // Lane selection for loads.
  always_comb begin
    byte_s = 8'h00;
    case (ld_addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (ld_addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension to the register width.
  always_comb begin
    load_fmt = 32'h0000_0000;
    case (ld_funct3)
      MEM_B:   load_fmt = {{24{byte_s[7]}}, byte_s};
      MEM_BU:  load_fmt = {24'h00_0000, byte_s};
      MEM_H:   load_fmt = {{16{half_s[15]}}, half_s};
      MEM_HU:  load_fmt = {16'h0000, half_s};
      MEM_W:   load_fmt = rdata;
      default: load_fmt = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_axi_lite.sv
// Load/store unit bridging the core's memory stage onto an AXI4-Lite master
// port; stalls the pipeline until the single transaction completes.
module lsu_axi_lite
  import single_cycle_defs::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              lsu_stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  lsu_state_e  state_r, next_state_s;
  logic        aw_done_r, w_done_r;
  logic [31:0] addr_r;
  logic [2:0]  funct3_r;
  logic [3:0]  wstrb_r;
  logic [31:0] wdata_r;
  logic [31:0] load_data_r;
  logic        misalign_err_r, bus_err_r;

  logic        awvalid_s, wvalid_s, aw_hs_s, w_hs_s;
  logic [3:0]  align_wstrb_s;
  logic [31:0] align_wdata_s, align_load_s;
  logic        misalign_s;

  lsu_align u_align (
    .st_funct3  (funct3),
    .st_addr_lo (addr[1:0]),
    .store_data (store_data),
    .ld_funct3  (funct3_r),
    .ld_addr_lo (addr_r[1:0]),
    .rdata      (m_rdata),
    .wstrb      (align_wstrb_s),
    .wdata      (align_wdata_s),
    .load_fmt   (align_load_s),
    .misalign   (misalign_s)
  );

  // Valids come from registered state only, never from the slave's ready.
  assign awvalid_s = (state_r == LSU_WR_REQ) && !aw_done_r;
  assign wvalid_s  = (state_r == LSU_WR_REQ) && !w_done_r;
  assign aw_hs_s   = awvalid_s && m_awready;
  assign w_hs_s    = wvalid_s && m_wready;

  assign m_awaddr  = ADDR_W'({addr_r[31:2], 2'b00});
  assign m_araddr  = ADDR_W'({addr_r[31:2], 2'b00});
  assign m_awprot  = PROT;
  assign m_arprot  = PROT;
  assign m_awvalid = awvalid_s;
  assign m_wvalid  = wvalid_s;
  assign m_wdata   = wdata_r;
  assign m_wstrb   = wstrb_r;
  assign m_bready  = (state_r == LSU_WR_RESP);
  assign m_arvalid = (state_r == LSU_RD_REQ);
  assign m_rready  = (state_r == LSU_RD_RESP);

  assign lsu_stall    = (mem_read || mem_write) && (state_r != LSU_DONE);
  assign load_data    = load_data_r;
  assign misalign_err = misalign_err_r;
  assign bus_err      = bus_err_r;

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if ((mem_read || mem_write) && misalign_s) begin
          next_state_s = LSU_DONE;
        end else if (mem_write) begin
          next_state_s = LSU_WR_REQ;
        end else if (mem_read) begin
          next_state_s = LSU_RD_REQ;
        end else begin
          next_state_s = LSU_IDLE;
        end
      end
      LSU_WR_REQ: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          next_state_s = LSU_WR_RESP;
        end else begin
          next_state_s = LSU_WR_REQ;
        end
      end
      LSU_WR_RESP: begin
        if (m_bvalid) begin
          next_state_s = LSU_DONE;
        end else begin
          next_state_s = LSU_WR_RESP;
        end
      end
      LSU_RD_REQ: begin
        if (m_arready) begin
          next_state_s = LSU_RD_RESP;
        end else begin
          next_state_s = LSU_RD_REQ;
        end
      end
      LSU_RD_RESP: begin
        if (m_rvalid) begin
          next_state_s = LSU_DONE;
        end else begin
          next_state_s = LSU_RD_RESP;
        end
      end
      LSU_DONE: next_state_s = LSU_IDLE;
      default:  next_state_s = LSU_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture, handshake tracking, load result and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_done_r      <= 1'b0;
      w_done_r       <= 1'b0;
      addr_r         <= 32'h0000_0000;
      funct3_r       <= 3'b000;
      wstrb_r        <= 4'h0;
      wdata_r        <= 32'h0000_0000;
      load_data_r    <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      bus_err_r      <= 1'b0;
    end else begin
      misalign_err_r <= 1'b0;
      bus_err_r      <= 1'b0;
      case (state_r)
        LSU_IDLE: begin
          if (mem_read || mem_write) begin
            addr_r    <= addr;
            funct3_r  <= funct3;
            wstrb_r   <= align_wstrb_s;
            wdata_r   <= align_wdata_s;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            if (misalign_s) begin
              misalign_err_r <= 1'b1;
              if (mem_read) begin
                load_data_r <= 32'h0000_0000;
              end
            end
          end
        end
        LSU_WR_REQ: begin
          aw_done_r <= aw_done_r || aw_hs_s;
          w_done_r  <= w_done_r || w_hs_s;
        end
        LSU_WR_RESP: begin
          if (m_bvalid && (m_bresp != AXI_RESP_OKAY)) begin
            bus_err_r <= 1'b1;
          end
        end
        LSU_RD_RESP: begin
          if (m_rvalid) begin
            if (m_rresp != AXI_RESP_OKAY) begin
              bus_err_r   <= 1'b1;
              load_data_r <= 32'h0000_0000;
            end else begin
              load_data_r <= align_load_s;
            end
          end
        end
        default: begin
          aw_done_r <= aw_done_r;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_axi_lite.md
LSU_AXI_LITE -- requirements
Module: lsu_axi_lite

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 The block SHALL have parameter PROT, default 3'b000, constant driven on AWPROT/ARPROT.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 mem_read  in  1  current instruction is a load.
REQ-006 mem_write  in  1  current instruction is a store; never high together with mem_read.
REQ-007 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  32  effective address (execute-stage ALU result).
REQ-009 store_data  in  32  rs2 value to store.
REQ-010 load_data  out  32  aligned, extended load result for writeback.
REQ-011 lsu_stall  out  1  hold PC and regfile write while high.
REQ-012 misalign_err  out  1  one-cycle pulse: misaligned or illegal access.
REQ-013 bus_err  out  1  one-cycle pulse: BRESP/RRESP not OKAY.
REQ-014 m_awaddr/awprot/awvalid out, awready in; m_wdata(32)/wstrb(4)/wvalid out, wready in; m_bresp(2)/bvalid in, bready out; m_araddr/arprot/arvalid out, arready in; m_rdata(32)/rresp(2)/rvalid in, rready out: AXI4-Lite master.

Function
REQ-015 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-016 IDLE: mem_write & aligned -> WR_REQ; mem_read & aligned -> RD_REQ; (mem_read|mem_write) & misaligned -> DONE with misalign_err set; else stay.
REQ-017 On leaving IDLE the block SHALL register addr, word-aligned address (addr[1:0] cleared), strobe, shifted write data and funct3.
REQ-018 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 outside the listed codes; no bus transaction is issued.
REQ-019 WR_REQ: awvalid and wvalid asserted independently; each drops after its own handshake; -> WR_RESP when both handshakes have completed (same or different cycles).
REQ-020 WR_RESP: bready=1; on bvalid -> DONE; bus_err set if bresp!=2'b00.
REQ-021 RD_REQ: arvalid=1; on arready -> RD_RESP.
REQ-022 RD_RESP: rready=1; on rvalid, register formatted rdata into load_data and -> DONE; bus_err set if rresp!=2'b00.
REQ-023 DONE: lsu_stall=0, misalign_err/bus_err valid this cycle only; -> IDLE unconditionally.
REQ-024 lsu_stall SHALL be (mem_read|mem_write) & state!=DONE, combinational; zero-wait-slave access therefore stalls 3 cycles and completes in cycle 4.
REQ-025 Valid signals SHALL NOT depend combinationally on ready; address/data/strobe stable while valid is high.
REQ-026 Store: SB wstrb=4'b0001<<addr[1:0], byte replicated on all lanes; SH wstrb=4'b0011<<addr[1:0], half replicated; SW wstrb=4'hF.
REQ-027 Load: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend; W pass-through.
REQ-028 load_data SHALL hold its value until the next completed load; set to 0 on misaligned load or bus error.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, all valid/ready outputs 0, load_data 0, error pulses 0, including mid-transaction (interconnect shares the reset).

Structure
REQ-030 lsu_state_e and mem_size_e (funct3 codes) SHALL be added to the shared single_cycle_defs package.
REQ-031 Combinational sub-module lsu_align SHALL hold strobe/write-data generation and load extraction/extension.

Verification
REQ-032 SW addr 0x100 data 0xDEADBEEF, zero-wait slave -> wstrb 4'hF, awaddr 0x100, stall 3 cycles, bus_err 0.
REQ-033 SB addr 0x103 data 0x000000A5 -> wstrb 4'b1000, wdata 0xA5A5A5A5, awaddr 0x100.
REQ-034 LB addr 0x202, rdata 0x12F45678 -> load_data 0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr 0x202 -> 0x000012F4.
REQ-035 LW addr 0x006 -> no arvalid, misalign_err pulse 1 cycle, load_data 0, stall released after 1 cycle.
REQ-036 SW with wready 3 cycles after awready, then bresp=2'b10 -> awvalid drops first, bus_err pulses in DONE.
REQ-037 rst_n low while in RD_RESP -> next edge IDLE, rready 0, lsu_stall follows inputs.
